// File: rtl/mem_req_master.sv
// Request master for a synchronous single-port RAM: queues CPU word requests in a
// small FIFO and issues them one at a time, returning read data with a done pulse.
module mem_req_master #(
   parameter int AW       = 9,
   parameter int DW       = 32,
   parameter int DEPTH    = 2,
   parameter int READ_LAT = 1
) (
   input  logic          clk,
   input  logic          clear_n,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ready,
   output logic          cpu_done,
   output logic          cpu_done_rd,
   output logic [DW-1:0] cpu_rdata,
   output logic          mem_read,
   output logic          mem_write,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [1:0]    fsm_state   // 0=IDLE 1=ISSUE 2=WAIT
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

   // Handshake: a request is taken on a rising edge where cpu_req and cpu_ready are both 1.
   state_t        state;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [LW-1:0] wait_cnt;
   logic          push;
   logic          pop;

   logic          fifo_we   [DEPTH];
   logic [AW-1:0] fifo_addr [DEPTH];
   logic [DW-1:0] fifo_data [DEPTH];

   assign push      = cpu_req & cpu_ready;
   assign pop       = (state == IDLE) && (count != '0);
   assign fsm_state = state;

   always_comb begin
      count_next = count;
      if (push && !pop)
         count_next = count + 1'b1;
      else if (!push && pop)
         count_next = count - 1'b1;
   end

   // Storage needs no reset: entries are only read once count says they are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_we[wr_ptr]   <= cpu_we;
         fifo_addr[wr_ptr] <= cpu_addr;
         fifo_data[wr_ptr] <= cpu_wdata;
      end
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state       <= IDLE;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         wait_cnt    <= '0;
         cpu_ready   <= 1'b1;
         cpu_done    <= 1'b0;
         cpu_done_rd <= 1'b0;
         cpu_rdata   <= '0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
      end else begin
         count       <= count_next;
         cpu_ready   <= (count_next != FULL);
         cpu_done    <= 1'b0;
         cpu_done_rd <= 1'b0;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         case (state)
            IDLE: begin
               if (count != '0) begin
                  rd_ptr    <= rd_ptr + 1'b1;
                  mem_addr  <= fifo_addr[rd_ptr];
                  mem_wdata <= fifo_data[rd_ptr];
                  mem_read  <= ~fifo_we[rd_ptr];
                  mem_write <= fifo_we[rd_ptr];
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               // The strobe itself tells which kind of op is in flight.
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               if (mem_write) begin
                  cpu_done <= 1'b1;
                  state    <= IDLE;
               end else begin
                  wait_cnt <= LW'(READ_LAT - 1);
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (wait_cnt == '0) begin
                  cpu_rdata   <= mem_rdata;
                  cpu_done    <= 1'b1;
                  cpu_done_rd <= 1'b1;
                  state       <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
